// File: rtl/execution_muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit: funct3 op codes, FSM states, decode helpers.
package execution_muldiv_pkg;

  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  typedef enum logic [2:0] {
    INST_MUL    = 3'b000,
    INST_MULH   = 3'b001,
    INST_MULHSU = 3'b010,
    INST_MULHU  = 3'b011,
    INST_DIV    = 3'b100,
    INST_DIVU   = 3'b101,
    INST_REM    = 3'b110,
    INST_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } muldiv_state_e;

  // True when funct7 marks an M-extension R-type instruction.
  function automatic logic is_m_funct7(input logic [6:0] funct7);
    return funct7 == FUNCT7_M;
  endfunction

endpackage

// File: rtl/execution_muldiv_if.sv
// Request/response bundle between the execution stage (master) and the mul/div unit (slave).
interface execution_muldiv_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            req_valid;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic [4:0]      req_rd;
  logic            flush;
  logic            req_ready;
  logic            hold_en;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic [4:0]      resp_rd;

  modport master (
    output req_valid, req_funct3, req_a, req_b, req_rd, flush,
    input  req_ready, hold_en, resp_valid, resp_data, resp_rd
  );

  modport slave (
    input  req_valid, req_funct3, req_a, req_b, req_rd, flush,
    output req_ready, hold_en, resp_valid, resp_data, resp_rd
  );

endinterface

// File: rtl/execution_muldiv_iter.sv
// One combinational iteration: shift-add multiply step or restoring-divide step on magnitudes.
// Multiply: {hi,lo} = {accumulator, multiplier}, operand = multiplicand.
// Divide:   {hi,lo} = {partial remainder, dividend/quotient}, operand = divisor.
module execution_muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Single step; the divide trial-subtract borrow is the top bit of diff.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, operand};
    hi_nxt  = '0;
    lo_nxt  = '0;
    if (is_div) begin
      if (!diff[XLEN]) begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/execution_muldiv.sv
// Iterative RV32M multiply/divide unit (generic XLEN) with pipeline hold and one-cycle result pulse.
// Optional macro FAST_MUL_EN: MUL* computed in one BUSY cycle with a signed (XLEN+1)x(XLEN+1) multiply.
module execution_muldiv
  import execution_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic               clk,
  input logic               rst,
  execution_muldiv_if.slave bus
);

  localparam int unsigned     CNT_W     = $clog2(XLEN) + 1;
  localparam int unsigned     PW        = 2 * XLEN;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  muldiv_op_e       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  mag_op_q, mag_op_d;
  logic             neg_q, neg_d;
  logic             spec_q, spec_d;
  logic [XLEN-1:0]  spec_res_q, spec_res_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]  resp_data_q, resp_data_d;
  logic [4:0]       resp_rd_q, resp_rd_d;

  // Request decode
  muldiv_op_e      f3;
  logic            sa, sb, dz, ovf, accept;
  logic [XLEN-1:0] mag_a, mag_b;

  // Datapath
  logic            iter_div;
  logic [XLEN-1:0] hi_nxt, lo_nxt;
  logic [PW-1:0]   prod, prod_s;
  logic [XLEN-1:0] quo_s, rem_s, iter_res;

`ifdef FAST_MUL_EN
  logic [XLEN-1:0]      a_q, a_d;
  logic [XLEN-1:0]      b_q, b_d;
  logic                 ea_q, ea_d;
  logic                 eb_q, eb_d;
  logic signed [PW-1:0] fa, fb, fprod;
  logic [XLEN-1:0]      fast_res;
  assign iter_div = 1'b1;
`else
  assign iter_div = op_q[2];
`endif

  execution_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .is_div  (iter_div),
    .hi      (hi_q),
    .lo      (lo_q),
    .operand (mag_op_q),
    .hi_nxt  (hi_nxt),
    .lo_nxt  (lo_nxt)
  );

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_rd    = resp_rd_q;
  assign bus.hold_en    = (state_q == ST_BUSY) ||
                          ((state_q == ST_IDLE) && bus.req_valid && !bus.flush);

  // Operand decode: signedness, magnitudes, divide-by-zero and signed overflow.
  always_comb begin
    f3     = muldiv_op_e'(bus.req_funct3);
    sa     = bus.req_a[XLEN-1] && (f3 inside {INST_MULH, INST_MULHSU, INST_DIV, INST_REM});
    sb     = bus.req_b[XLEN-1] && (f3 inside {INST_MULH, INST_DIV, INST_REM});
    mag_a  = sa ? -bus.req_a : bus.req_a;
    mag_b  = sb ? -bus.req_b : bus.req_b;
    dz     = f3[2] && (bus.req_b == '0);
    ovf    = (f3 inside {INST_DIV, INST_REM}) && (bus.req_a == INT_MIN) && (bus.req_b == '1);
    accept = (state_q == ST_IDLE) && bus.req_valid && !bus.flush;
  end

  // Final result from the last iteration, with sign correction applied.
  always_comb begin
    prod   = {hi_nxt, lo_nxt};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_nxt : lo_nxt;
    rem_s  = neg_q ? -hi_nxt : hi_nxt;
    if (op_q[2]) begin
      iter_res = op_q[1] ? rem_s : quo_s;
    end else begin
      iter_res = (op_q == INST_MUL) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
    end
  end

`ifdef FAST_MUL_EN
  // Single-cycle signed multiply on sign/zero-extended operands.
  always_comb begin
    fa       = PW'($signed({ea_q, a_q}));
    fb       = PW'($signed({eb_q, b_q}));
    fprod    = fa * fb;
    fast_res = (op_q == INST_MUL) ? fprod[XLEN-1:0] : fprod[PW-1:XLEN];
  end
`endif

  // Next-state and register updates for the FSM and datapath.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    rd_d         = rd_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mag_op_d     = mag_op_q;
    neg_d        = neg_q;
    spec_d       = spec_q;
    spec_res_d   = spec_res_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
`ifdef FAST_MUL_EN
    a_d          = a_q;
    b_d          = b_q;
    ea_d         = ea_q;
    eb_d         = eb_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_BUSY;
          cnt_d      = '0;
          op_d       = f3;
          rd_d       = bus.req_rd;
          hi_d       = '0;
          lo_d       = f3[2] ? mag_a : mag_b;
          mag_op_d   = f3[2] ? mag_b : mag_a;
          neg_d      = (f3 == INST_REM) ? sa : (sa ^ sb);
          spec_d     = dz || ovf;
          spec_res_d = !f3[1] ? (dz ? '1 : bus.req_a) : (dz ? bus.req_a : '0);
`ifdef FAST_MUL_EN
          a_d        = bus.req_a;
          b_d        = bus.req_b;
          ea_d       = sa;
          eb_d       = sb;
`endif
        end
      end
      ST_BUSY: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (spec_q) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b1;
          resp_data_d  = spec_res_q;
          resp_rd_d    = rd_q;
`ifdef FAST_MUL_EN
        end else if (!op_q[2]) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b1;
          resp_data_d  = fast_res;
          resp_rd_d    = rd_q;
`endif
        end else begin
          hi_d  = hi_nxt;
          lo_d  = lo_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b1;
            resp_data_d  = iter_res;
            resp_rd_d    = rd_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= INST_MUL;
      rd_q         <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mag_op_q     <= '0;
      neg_q        <= 1'b0;
      spec_q       <= 1'b0;
      spec_res_q   <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
`ifdef FAST_MUL_EN
      a_q          <= '0;
      b_q          <= '0;
      ea_q         <= 1'b0;
      eb_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mag_op_q     <= mag_op_d;
      neg_q        <= neg_d;
      spec_q       <= spec_d;
      spec_res_q   <= spec_res_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
`ifdef FAST_MUL_EN
      a_q          <= a_d;
      b_q          <= b_d;
      ea_q         <= ea_d;
      eb_q         <= eb_d;
`endif
    end
  end

endmodule
